// File: rtl/buzzer_arbiter.sv
// buzzer_arbiter: shares one piezo buzzer between key-click, unlock-success
// and wrong-code alarm sounds. Requests are 1-cycle pulses resolved by fixed
// priority (err > ok > key); each pattern is timed by internal counters.
// Optional build macro BUZZ_QUEUE_EN adds a one-entry pending register that
// remembers a dropped lower-priority request and plays it afterwards.
module buzzer_arbiter #(
  parameter int KEY_HALF = 50000,
  parameter int KEY_LEN  = 10000000,
  parameter int OK_HALF  = 25000,
  parameter int OK_LEN   = 30000000,
  parameter int ERR_HALF = 100000,
  parameter int ERR_ON   = 5000000,
  parameter int ERR_GAP  = 5000000,
  parameter int CW       = 32
) (
  input  logic       clk,
  input  logic       RSTn,
  input  logic       req_key,
  input  logic       req_ok,
  input  logic       req_err,
  output logic       buzzer,
  output logic       busy,
  output logic [1:0] active_id
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,
    S_OK,
    S_ERR_ON1,
    S_ERR_GAP,
    S_ERR_ON2
  } state_t;

  localparam logic [CW-1:0] KEY_HALF_M1 = CW'(KEY_HALF - 1);
  localparam logic [CW-1:0] KEY_LEN_M1  = CW'(KEY_LEN - 1);
  localparam logic [CW-1:0] OK_HALF_M1  = CW'(OK_HALF - 1);
  localparam logic [CW-1:0] OK_LEN_M1   = CW'(OK_LEN - 1);
  localparam logic [CW-1:0] ERR_HALF_M1 = CW'(ERR_HALF - 1);
  localparam logic [CW-1:0] ERR_ON_M1   = CW'(ERR_ON - 1);
  localparam logic [CW-1:0] ERR_GAP_M1  = CW'(ERR_GAP - 1);

  state_t        state;
  logic [CW-1:0] tcnt;
  logic [CW-1:0] dcnt;
  logic [1:0]    req_prio;
  logic [1:0]    start_prio;
  logic [CW-1:0] half_m1;
  logic          seg_end;
  logic          term;
`ifdef BUZZ_QUEUE_EN
  logic [1:0]    pend;
`endif

  // Priority of this cycle's request (0 = none, 1 key, 2 ok, 3 err)
  always_comb begin
    req_prio = 2'd0;
    if (req_err)      req_prio = 2'd3;
    else if (req_ok)  req_prio = 2'd2;
    else if (req_key) req_prio = 2'd1;
  end

  // Pattern identity follows the state; the gap still belongs to the alarm
  always_comb begin
    active_id = 2'd0;
    case (state)
      S_KEY:                          active_id = 2'd1;
      S_OK:                           active_id = 2'd2;
      S_ERR_ON1, S_ERR_GAP, S_ERR_ON2: active_id = 2'd3;
      default:                        active_id = 2'd0;
    endcase
  end

  assign busy = (state != S_IDLE);

  // Tone half period and end-of-segment detection for the current state
  always_comb begin
    half_m1 = '0;
    seg_end = 1'b0;
    case (state)
      S_KEY: begin
        half_m1 = KEY_HALF_M1;
        seg_end = (dcnt == KEY_LEN_M1);
      end
      S_OK: begin
        half_m1 = OK_HALF_M1;
        seg_end = (dcnt == OK_LEN_M1);
      end
      S_ERR_ON1, S_ERR_ON2: begin
        half_m1 = ERR_HALF_M1;
        seg_end = (dcnt == ERR_ON_M1);
      end
      default: begin
        half_m1 = '0;
        seg_end = 1'b0;
      end
    endcase
    term = seg_end && (state != S_ERR_ON1);
  end

  // Decide whether a pattern (re)starts on this edge and which one
  always_comb begin
    start_prio = 2'd0;
    if (req_prio != 2'd0 && (req_prio >= active_id || term))
      start_prio = req_prio;
`ifdef BUZZ_QUEUE_EN
    else if (term && pend != 2'd0)
      start_prio = pend;
`endif
  end

  // Pattern sequencer: start/restart, tone generation, gap and termination
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state  <= S_IDLE;
      buzzer <= 1'b0;
      tcnt   <= '0;
      dcnt   <= '0;
`ifdef BUZZ_QUEUE_EN
      pend   <= 2'd0;
`endif
    end else if (start_prio != 2'd0) begin
      case (start_prio)
        2'd1:    state <= S_KEY;
        2'd2:    state <= S_OK;
        default: state <= S_ERR_ON1;
      endcase
      buzzer <= 1'b1;
      tcnt   <= '0;
      dcnt   <= '0;
`ifdef BUZZ_QUEUE_EN
      if (start_prio >= pend)
        pend <= 2'd0;
`endif
    end else begin
`ifdef BUZZ_QUEUE_EN
      if (req_prio > pend)
        pend <= req_prio;
`endif
      case (state)
        S_KEY, S_OK, S_ERR_ON1, S_ERR_ON2: begin
          if (seg_end) begin
            state  <= (state == S_ERR_ON1) ? S_ERR_GAP : S_IDLE;
            buzzer <= 1'b0;
            tcnt   <= '0;
            dcnt   <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
            if (tcnt == half_m1) begin
              buzzer <= ~buzzer;
              tcnt   <= '0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        S_ERR_GAP: begin
          buzzer <= 1'b0;
          tcnt   <= '0;
          if (dcnt == ERR_GAP_M1) begin
            state  <= S_ERR_ON2;
            buzzer <= 1'b1;
            dcnt   <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          buzzer <= 1'b0;
          tcnt   <= '0;
          dcnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Testbench for buzzer_arbiter: directed scenarios with literal expectations
// plus a pattern-timeline model checked against the DUT on every cycle.
module tb_buzzer_arbiter;

  localparam int KEY_HALF = 2;
  localparam int KEY_LEN  = 12;
  localparam int OK_HALF  = 1;
  localparam int OK_LEN   = 8;
  localparam int ERR_HALF = 3;
  localparam int ERR_ON   = 6;
  localparam int ERR_GAP  = 4;
`ifdef BUZZ_QUEUE_EN
  localparam int QUEUE = 1;
`else
  localparam int QUEUE = 0;
`endif

  logic       clk;
  logic       RSTn;
  logic       req_key;
  logic       req_ok;
  logic       req_err;
  logic       buzzer;
  logic       busy;
  logic [1:0] active_id;

  int checks;
  int failures;
  int busy_total;

  int m_kind;
  int m_t;
  int m_pend;

  buzzer_arbiter #(
    .KEY_HALF(KEY_HALF), .KEY_LEN(KEY_LEN), .OK_HALF(OK_HALF), .OK_LEN(OK_LEN),
    .ERR_HALF(ERR_HALF), .ERR_ON(ERR_ON), .ERR_GAP(ERR_GAP), .CW(32)
  ) dut (
    .clk(clk), .RSTn(RSTn), .req_key(req_key), .req_ok(req_ok), .req_err(req_err),
    .buzzer(buzzer), .busy(busy), .active_id(active_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Total length of each pattern in cycles
  function automatic int patLen(input int k);
    case (k)
      1:       return KEY_LEN;
      2:       return OK_LEN;
      3:       return 2 * ERR_ON + ERR_GAP;
      default: return 0;
    endcase
  endfunction

  // Buzzer level t cycles into a pattern: a square wave starting high
  function automatic int expBuz(input int k, input int t);
    case (k)
      1: return ((t / KEY_HALF) % 2 == 0) ? 1 : 0;
      2: return ((t / OK_HALF) % 2 == 0) ? 1 : 0;
      3: begin
        if (t < ERR_ON) return ((t / ERR_HALF) % 2 == 0) ? 1 : 0;
        if (t < ERR_ON + ERR_GAP) return 0;
        return (((t - ERR_ON - ERR_GAP) / ERR_HALF) % 2 == 0) ? 1 : 0;
      end
      default: return 0;
    endcase
  endfunction

  // Model: which pattern plays and how far into it we are
  always @(posedge clk or negedge RSTn) begin
    int rp, k, t, p;
    bit ends;
    if (!RSTn) begin
      m_kind <= 0;
      m_t    <= 0;
      m_pend <= 0;
    end else begin
      rp = req_err ? 3 : req_ok ? 2 : req_key ? 1 : 0;
      k = m_kind; t = m_t; p = m_pend;
      ends = (k != 0) && (t == patLen(k) - 1);
      if (rp != 0 && (rp >= k || ends)) begin
        if (rp >= p) p = 0;
        k = rp; t = 0;
      end else begin
        if (QUEUE != 0 && rp > p) p = rp;
        if (ends) begin
          if (p != 0) begin k = p; t = 0; p = 0; end
          else k = 0;
        end else if (k != 0) begin
          t = t + 1;
        end
      end
      m_kind <= k;
      m_t    <= t;
      m_pend <= p;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (RSTn) begin
      checkOutput("model_buzzer", int'(buzzer), expBuz(m_kind, m_t));
      checkOutput("model_busy", int'(busy), (m_kind != 0) ? 1 : 0);
      checkOutput("model_id", int'(active_id), m_kind);
      busy_total <= busy_total + int'(busy);
    end
  end

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  // Present a one-cycle request pulse; returns showing the first cycle after it
  task automatic applyStimulus(input logic k, input logic o, input logic e);
    req_key = k; req_ok = o; req_err = e;
    nextCycle();
    req_key = 1'b0; req_ok = 1'b0; req_err = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      nextCycle();
      n++;
    end
    if (n >= 100) checkOutput("idle_timeout", 1, 0);
    nextCycle();
    nextCycle();
  endtask

  initial begin
    int base;
    int seq1 [12] = '{1,1,0,0,1,1,0,0,1,1,0,0};
    int seq2 [16] = '{1,1,1,0,0,0, 0,0,0,0, 1,1,1,0,0,0};
    checks = 0; failures = 0; busy_total = 0;
    RSTn = 1'b0; req_key = 1'b0; req_ok = 1'b0; req_err = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("reset_buzzer", int'(buzzer), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_id", int'(active_id), 0);
    RSTn = 1'b1;
    nextCycle();

    // Key click
    base = busy_total;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      checkOutput("t1_buzzer", int'(buzzer), seq1[i]);
      checkOutput("t1_id", int'(active_id), 1);
      nextCycle();
    end
    checkOutput("t1_end_busy", int'(busy), 0);
    checkOutput("t1_end_id", int'(active_id), 0);
    waitIdle();
    checkOutput("t1_len", busy_total - base, 12);

    // Alarm: burst, gap, burst
    base = busy_total;
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      checkOutput("t2_buzzer", int'(buzzer), seq2[i]);
      checkOutput("t2_id", int'(active_id), 3);
      nextCycle();
    end
    checkOutput("t2_end_busy", int'(busy), 0);
    waitIdle();
    checkOutput("t2_len", busy_total - base, 16);

    // OK preempts key
    base = busy_total;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t3_id", int'(active_id), 2);
    checkOutput("t3_buz0", int'(buzzer), 1);
    nextCycle();
    checkOutput("t3_buz1", int'(buzzer), 0);
    waitIdle();
    checkOutput("t3_len", busy_total - base, 13);

    // Key during alarm gap
    base = busy_total;
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t4_id_gap", int'(active_id), 3);
    checkOutput("t4_buz_gap", int'(buzzer), 0);
    for (int i = 0; i < 8; i++) nextCycle();
    checkOutput("t4_id_after", int'(active_id), QUEUE);
    waitIdle();
    checkOutput("t4_len", busy_total - base, 16 + QUEUE * 12);

    // Simultaneous requests
    base = busy_total;
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t5_id", int'(active_id), 3);
    waitIdle();
    checkOutput("t5_len", busy_total - base, 16);

    // Asynchronous reset mid-OK
    applyStimulus(1'b0, 1'b1, 1'b0);
    nextCycle();
    nextCycle();
    #2;
    RSTn = 1'b0;
    #1;
    checkOutput("t6_rst_buzzer", int'(buzzer), 0);
    checkOutput("t6_rst_busy", int'(busy), 0);
    checkOutput("t6_rst_id", int'(active_id), 0);
    nextCycle();
    RSTn = 1'b1;
    nextCycle();
    base = busy_total;
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitIdle();
    checkOutput("t6_len", busy_total - base, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
